// File: rtl/ram_arbiter.sv
// Round-robin two-port arbiter/sequencer for a single-port sync RAM.
// Optional post-reset memory clear: define RAM_ARB_MEM_INIT_EN.
module ram_arbiter #(
  parameter int AW       = 4,
  parameter int DW       = 4,
  parameter int LED_BITS = 24
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          gnt0,
  output logic          rvalid0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt1,
  output logic          rvalid1,
  output logic [DW-1:0] rdata1,
  output logic          ram_wr,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_data,
  input  logic [DW-1:0] ram_q,
  output logic          busy,
  output logic          led
);

  logic                last;
  logic                serve;
  logic                init_wr;
  logic [AW-1:0]       init_addr;
  logic                win0;
  logic                win1;
  logic [LED_BITS-1:0] act_cnt;
  logic [LED_BITS-1:0] cnt_nxt;

`ifdef RAM_ARB_MEM_INIT_EN
  typedef enum logic {INIT, SERVE} state_t;
  state_t state;
  state_t state_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= INIT;
      init_addr <= '0;
    end else begin
      state <= state_nxt;
      if (state == INIT)
        init_addr <= init_addr + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    if (state == INIT && init_addr == '1)
      state_nxt = SERVE;
  end

  assign busy    = (state == INIT);
  assign serve   = rst && (state == SERVE);
  assign init_wr = rst && (state == INIT);
`else
  assign busy      = 1'b0;
  assign serve     = rst;
  assign init_wr   = 1'b0;
  assign init_addr = '0;
`endif

  // tie goes to whoever was not served last
  assign win0 = req0 && (!req1 || last);
  assign win1 = req1 && (!req0 || !last);

  always_comb begin
    gnt0     = 1'b0;
    gnt1     = 1'b0;
    ram_wr   = 1'b0;
    ram_addr = '0;
    ram_data = '0;
    if (init_wr) begin
      ram_wr   = 1'b1;
      ram_addr = init_addr;
    end else if (serve) begin
      unique case (1'b1)
        win0: begin
          gnt0     = 1'b1;
          ram_wr   = we0;
          ram_addr = addr0;
          ram_data = wdata0;
        end
        win1: begin
          gnt1     = 1'b1;
          ram_wr   = we1;
          ram_addr = addr1;
          ram_data = wdata1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    cnt_nxt = act_cnt;
    if (gnt0 || gnt1)
      cnt_nxt = '1;
    else if (act_cnt != '0)
      cnt_nxt = act_cnt - 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last    <= 1'b1;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      act_cnt <= '0;
      led     <= 1'b0;
    end else begin
      if (gnt0)
        last <= 1'b0;
      else if (gnt1)
        last <= 1'b1;
      rvalid0 <= gnt0 && !we0;
      rvalid1 <= gnt1 && !we1;
      act_cnt <= cnt_nxt;
      led     <= (cnt_nxt != '0);
    end
  end

  assign rdata0 = rvalid0 ? ram_q : '0;
  assign rdata1 = rvalid1 ? ram_q : '0;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed scoreboard bench for ram_arbiter with a behavioural 16x4 RAM.
// Follows RAM_ARB_MEM_INIT_EN the same way the design does.
module tb_ram_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, we0, req1, we1;
  logic [3:0] addr0, wdata0, addr1, wdata1;
  logic       gnt0, gnt1, rvalid0, rvalid1;
  logic [3:0] rdata0, rdata1;
  logic       ram_wr;
  logic [3:0] ram_addr, ram_data;
  logic [3:0] ram_q;
  logic       busy, led;

  logic [3:0] mem [16];
  logic [3:0] shadow [16];

  typedef struct packed {
    logic       id;
    logic [3:0] d;
  } exp_t;
  exp_t sb [$];

  int total = 0;
  int pass  = 0;

  ram_arbiter #(.AW(4), .DW(4), .LED_BITS(3)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .ram_wr(ram_wr), .ram_addr(ram_addr), .ram_data(ram_data),
    .ram_q(ram_q), .busy(busy), .led(led)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_wr) mem[ram_addr] <= ram_data;
    else        ram_q <= mem[ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic pop_chk();
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("rvalid0", rvalid0, e.id == 1'b0);
      chk("rvalid1", rvalid1, e.id == 1'b1);
      if (e.id) chk("rdata1", rdata1, e.d);
      else      chk("rdata0", rdata0, e.d);
    end else begin
      chk("rvalid0_idle", rvalid0, 0);
      chk("rvalid1_idle", rvalid1, 0);
    end
  endtask

  // called just after a posedge with inputs already driven
  task automatic cyc(input bit e0, input bit e1);
    #1;
    chk("gnt0", gnt0, e0);
    chk("gnt1", gnt1, e1);
    if (e0) begin
      chk("cmd_wr0", ram_wr, we0);
      chk("cmd_addr0", ram_addr, addr0);
      if (we0) shadow[addr0] = wdata0;
      else     sb.push_back('{1'b0, shadow[addr0]});
    end else if (e1) begin
      chk("cmd_wr1", ram_wr, we1);
      chk("cmd_addr1", ram_addr, addr1);
      if (we1) shadow[addr1] = wdata1;
      else     sb.push_back('{1'b1, shadow[addr1]});
    end else begin
      chk("idle_wr", ram_wr, 0);
      chk("idle_addr", ram_addr, 0);
    end
    @(posedge clk);
    #1;
    pop_chk();
  endtask

  task automatic init_wait();
`ifdef RAM_ARB_MEM_INIT_EN
    for (int i = 0; i < 16; i++) begin
      #1;
      chk("init_wr", ram_wr, 1);
      chk("init_addr", ram_addr, i);
      chk("init_busy", busy, 1);
      chk("init_nogrant", {gnt0, gnt1}, 0);
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < 16; i++) shadow[i] = 4'h0;
    chk("busy_after_init", busy, 0);
`else
    chk("busy_noinit", busy, 0);
`endif
  endtask

  task automatic idle(input int n);
    req0 = 1'b0;
    req1 = 1'b0;
    for (int i = 0; i < n; i++) cyc(0, 0);
  endtask

  initial begin
    rst = 1'b0;
    req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
    req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;

    // reset with random inputs
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      {req0, we0, req1, we1} = 4'($urandom);
      {addr0, wdata0, addr1, wdata1} = 16'($urandom);
      #2;
      chk("rst_gnt", {gnt0, gnt1}, 0);
      chk("rst_rvalid", {rvalid0, rvalid1}, 0);
      chk("rst_rdata", {rdata0, rdata1}, 0);
      chk("rst_cmd", {ram_wr, ram_addr, ram_data}, 0);
      chk("rst_led", led, 0);
`ifdef RAM_ARB_MEM_INIT_EN
      chk("rst_busy", busy, 1);
`else
      chk("rst_busy", busy, 0);
`endif
    end

    // release; hold a read of addr 5 across init
    @(posedge clk);
    #1;
    req0 = 1; we0 = 0; addr0 = 5;
    req1 = 0;
    rst  = 1'b1;
    init_wait();
`ifdef RAM_ARB_MEM_INIT_EN
    cyc(1, 0);
`endif
    idle(1);

    // single requester write then read
    req0 = 1; we0 = 1; addr0 = 3; wdata0 = 4'hA;
    cyc(1, 0);
    we0 = 0;
    cyc(1, 0);
    idle(1);

    // preload, then both hammer reads
    req0 = 1; we0 = 1; addr0 = 1; wdata0 = 4'h1;
    cyc(1, 0);
    req0 = 0;
    req1 = 1; we1 = 1; addr1 = 2; wdata1 = 4'h2;
    cyc(0, 1);
    req0 = 1; we0 = 0; addr0 = 1;
    req1 = 1; we1 = 0; addr1 = 2;
    for (int i = 0; i < 6; i++) cyc(i % 2 == 0, i % 2 == 1);
    idle(1);

    // read-after-write across requesters
    req1 = 1; we1 = 1; addr1 = 7; wdata1 = 4'hC;
    cyc(0, 1);
    req1 = 0;
    req0 = 1; we0 = 0; addr0 = 7;
    cyc(1, 0);
    idle(8);
    chk("led_idle", led, 0);

    // led stretch and reload
    req0 = 1; we0 = 0; addr0 = 3;
    cyc(1, 0);
    chk("led_on", led, 1);
    for (int k = 2; k <= 7; k++) begin
      idle(1);
      chk("led_hold", led, 1);
    end
    idle(1);
    chk("led_off", led, 0);
    req0 = 1;
    cyc(1, 0);
    idle(3);
    req0 = 1;
    cyc(1, 0);
    for (int k = 2; k <= 7; k++) begin
      idle(1);
      chk("led_reload", led, 1);
    end
    idle(1);
    chk("led_reload_off", led, 0);

    // reset right after a granted read
    req0 = 1; we0 = 0; addr0 = 1;
    #1;
    chk("pre_rst_gnt0", gnt0, 1);
    @(posedge clk);
    #1;
    rst  = 1'b0;
    req0 = 0;
    #1;
    chk("midrst_rvalid", {rvalid0, rvalid1}, 0);
    chk("midrst_led", led, 0);
    @(posedge clk);
    #1;
    req0 = 1; we0 = 0; addr0 = 1;
    req1 = 1; we1 = 0; addr1 = 2;
    #1;
    chk("midrst_gnt", {gnt0, gnt1}, 0);
    rst = 1'b1;
    init_wait();
    cyc(1, 0);
    req0 = 0;
    cyc(0, 1);
    idle(2);

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
